lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 137 +++++++++++++
 tb/tb_lfsr_checker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// PRBS checker for the team 8-bit generator: hunts for a seed, verifies LOCK_CNT matches, then flywheels while locked.
// Latency: outputs are registered, updated one clock after the sample. Backpressure: none, samples consumed whenever in_valid=1.
// Optional saturating error counter enabled by macro LFSR_CHECKER_ERRCNT_EN (otherwise err_count is tied to zero).
module lfsr_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        restart,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [7:0]  expected
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

  // Generator step: q[6] falls off the top, feedback enters at both ends.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    logic f;
    f = q[7] ^ q[5] ^ q[4] ^ q[3];
    return {f, q[5:0], f};
  endfunction

  state_t     state;
  logic [3:0] good;
  logic [3:0] bad;
  logic       match;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;
  logic [7:0] seed_next;
  logic [7:0] fly_next;

  assign match     = (in_data == expected);
  assign good_inc  = good + 4'd1;
  assign bad_inc   = bad + 4'd1;
  assign seed_next = lfsr_next(in_data);
  assign fly_next  = lfsr_next(expected);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= HUNT;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      expected  <= 8'h00;
      good      <= 4'd0;
      bad       <= 4'd0;
    end else begin
      err_pulse <= 1'b0;
      if (restart) begin
        state    <= HUNT;
        locked   <= 1'b0;
        expected <= 8'h00;
        good     <= 4'd0;
        bad      <= 4'd0;
      end else if (in_valid) begin
        case (state)
          HUNT: begin
            // An all-zero word is the generator lock-up state and never seeds.
            if (in_data != 8'h00) begin
              expected <= seed_next;
              good     <= 4'd0;
              state    <= VERIFY;
            end
          end
          VERIFY: begin
            expected <= seed_next;
            if (match) begin
              good <= good_inc;
              if (good_inc == LOCK_TGT) begin
                state  <= LOCKED;
                locked <= 1'b1;
                bad    <= 4'd0;
              end
            end else begin
              good <= 4'd0;
              if (in_data == 8'h00) begin
                state <= HUNT;
              end
            end
          end
          LOCKED: begin
            // Flywheel on our own prediction so a corrupted word cannot pull us off sequence.
            expected <= fly_next;
            if (match) begin
              bad <= 4'd0;
            end else begin
              err_pulse <= 1'b1;
              if (bad_inc == LOSS_TGT) begin
                state  <= HUNT;
                locked <= 1'b0;
                bad    <= 4'd0;
              end else begin
                bad <= bad_inc;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            good   <= 4'd0;
            bad    <= 4'd0;
          end
        endcase
      end
    end
  end

`ifdef LFSR_CHECKER_ERRCNT_EN
  logic locked_err;

  assign locked_err = in_valid && (state == LOCKED) && !match;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      err_count <= 16'h0000;
    end else if (restart) begin
      err_count <= 16'h0000;
    end else if (locked_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'h0001;
    end
  end
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a reference model predicts outputs per driven sample, a monitor compares one cycle later.
module tb_lfsr_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic        clk;
  logic        clr;
  logic        restart;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [7:0]  expected;

  lfsr_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) u_dut (
    .clk       (clk),
    .clr       (clr),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .expected  (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] q);
    logic f;
    f = q[7] ^ q[5] ^ q[4] ^ q[3];
    return {f, q[5:0], f};
  endfunction

  // Reference model
  int         m_st;
  logic [7:0] m_exp;
  int         m_good;
  int         m_bad;
  bit         m_lock;
  bit         m_pulse;
  int         m_cnt;

  task automatic model_reset();
    m_st = 0; m_exp = 8'h00; m_good = 0; m_bad = 0;
    m_lock = 1'b0; m_pulse = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit rs);
    m_pulse = 1'b0;
    if (rs) begin
      model_reset();
    end else if (v) begin
      case (m_st)
        0: if (d != 8'h00) begin
          m_exp = nxt(d); m_good = 0; m_st = 1;
        end
        1: begin
          if (d == m_exp) begin
            m_good++;
            if (m_good == LOCK) begin m_st = 2; m_lock = 1'b1; m_bad = 0; end
          end else begin
            m_good = 0;
            if (d == 8'h00) m_st = 0;
          end
          m_exp = nxt(d);
        end
        default: begin
          if (d == m_exp) begin
            m_bad = 0;
          end else begin
            m_bad++;
            m_pulse = 1'b1;
`ifdef LFSR_CHECKER_ERRCNT_EN
            if (m_cnt < 65535) m_cnt++;
`endif
            if (m_bad == LOSS) begin m_st = 0; m_lock = 1'b0; m_bad = 0; end
          end
          m_exp = nxt(m_exp);
        end
      endcase
    end
  endtask

  typedef struct {
    string       tag;
    bit          lk;
    bit          pu;
    logic [15:0] cnt;
    logic [7:0]  ex;
  } sb_t;

  sb_t sb[$];

  task automatic send(input bit v, input logic [7:0] d, input bit rs, input string tag);
    sb_t e;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    restart  = rs;
    model_step(v, d, rs);
    e.tag = tag; e.lk = m_lock; e.pu = m_pulse; e.cnt = 16'(m_cnt); e.ex = m_exp;
    sb.push_back(e);
  endtask

  sb_t e_mon;
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e_mon = sb.pop_front();
      chk({e_mon.tag, ".locked"},    32'(locked),    32'(e_mon.lk));
      chk({e_mon.tag, ".err_pulse"}, 32'(err_pulse), 32'(e_mon.pu));
      chk({e_mon.tag, ".err_count"}, 32'(err_count), 32'(e_mon.cnt));
      chk({e_mon.tag, ".expected"},  32'(expected),  32'(e_mon.ex));
    end
  end

  task automatic lock_seq(input string tag);
    send(1, 8'h01, 0, {tag, "_s01"});
    send(1, 8'h02, 0, {tag, "_s02"});
    send(1, 8'h04, 0, {tag, "_s04"});
    send(1, 8'h08, 0, {tag, "_s08"});
    send(1, 8'h91, 0, {tag, "_s91"});
  endtask

  // Idle one cycle and wait until the monitor has consumed everything.
  task automatic settle();
    send(0, 8'h00, 0, "idle");
    @(posedge clk);
    #3;
  endtask

`ifdef LFSR_CHECKER_ERRCNT_EN
  logic        s_restart;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_locked;
  logic        s_pulse;
  logic [15:0] s_cnt;
  logic [7:0]  s_exp;

  lfsr_checker #(.LOCK_CNT(1), .LOSS_CNT(15)) u_sat (
    .clk       (clk),
    .clr       (clr),
    .restart   (s_restart),
    .in_valid  (s_valid),
    .in_data   (s_data),
    .locked    (s_locked),
    .err_pulse (s_pulse),
    .err_count (s_cnt),
    .expected  (s_exp)
  );

  task automatic sat_run();
    logic [7:0] se;
    int         errs;
    @(negedge clk); s_valid = 1'b1; s_data = 8'h01;
    @(negedge clk); s_data = 8'h02;
    se = nxt(8'h02);
    errs = 0;
    while (errs < 65540) begin
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (k < 14) begin s_data = se ^ 8'hFF; errs++; end
        else        s_data = se;
        se = nxt(se);
      end
    end
    @(negedge clk); s_valid = 1'b0;
    @(posedge clk); #1;
    chk("sat_err_count", 32'(s_cnt), 32'h0000FFFF);
    chk("sat_locked", 32'(s_locked), 32'd1);
    chk("sat_expected", 32'(s_exp), 32'(se));
  endtask
`endif

  initial begin
    clr = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = 8'h00;
`ifdef LFSR_CHECKER_ERRCNT_EN
    s_restart = 1'b0; s_valid = 1'b0; s_data = 8'h00;
`endif
    model_reset();
    #1;
    chk("rst_locked",    32'(locked),    32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_expected",  32'(expected),  32'd0);
    repeat (3) @(negedge clk);
    #2 clr = 1'b1;

    // Reference lock-in sequence, then a single corrupted word mid-lock.
    lock_seq("lock");
    settle();
    chk("lock_expected_22", 32'(expected), 32'h22);
    chk("lock_locked", 32'(locked), 32'd1);
    send(1, m_exp, 0, "one_good");
    send(1, 8'h55, 0, "one_bad");
    send(0, 8'h55, 0, "hold");
    send(1, m_exp, 0, "one_resume");
    settle();
    chk("one_err_still_locked", 32'(locked), 32'd1);

    // Three consecutive wrong words drop lock; next nonzero word re-seeds.
    for (int i = 0; i < 3; i++) send(1, m_exp ^ 8'hFF, 0, $sformatf("loss%0d", i));
    send(1, 8'h3C, 0, "reseed");
    settle();
    chk("reseed_expected_f9", 32'(expected), 32'hF9);

    // Restart, zero words in HUNT, then a seed and VERIFY mismatch handling.
    send(1, 8'h77, 1, "restart_hunt");
    send(1, 8'h00, 0, "hunt_zero0");
    send(1, 8'h00, 0, "hunt_zero1");
    send(1, 8'h01, 0, "hunt_seed");
    settle();
    chk("hunt_seed_expected_02", 32'(expected), 32'h02);
    send(1, 8'h02, 0, "ver_match");
    send(1, 8'h77, 0, "ver_reseed");
    send(1, 8'h00, 0, "ver_zero_hunt");
    send(1, 8'h00, 0, "hunt_after_zero");

    // Restart concurrent with a valid sample while locked.
    lock_seq("relock");
    send(1, 8'h00, 0, "relock_err");
    send(1, m_exp, 1, "restart_locked");
    settle();
    chk("restart_locked_low", 32'(locked), 32'd0);

    // Asynchronous clear in the middle of VERIFY.
    send(1, 8'h01, 0, "pre_clr_seed");
    send(1, 8'h02, 0, "pre_clr_match");
    settle();
    clr = 1'b0;
    #1;
    chk("aclr_locked",    32'(locked),    32'd0);
    chk("aclr_err_pulse", 32'(err_pulse), 32'd0);
    chk("aclr_err_count", 32'(err_count), 32'd0);
    chk("aclr_expected",  32'(expected),  32'd0);
    model_reset();
    @(negedge clk);
    #2 clr = 1'b1;
    send(1, 8'h05, 0, "post_clr_seed");
    send(1, nxt(8'h05), 0, "post_clr_match");

    // Mixed traffic: mostly correct words, some corruption, idles and rare restarts.
    for (int i = 0; i < 400; i++) begin
      bit         v;
      bit         rs;
      logic [7:0] d;
      v  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 79) == 0);
      d  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : m_exp;
      if (m_st == 0 && d == 8'h00) d = 8'($urandom_range(1, 255));
      send(v, d, rs, $sformatf("rnd%0d", i));
    end
    settle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

`ifdef LFSR_CHECKER_ERRCNT_EN
    sat_run();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
